dmem_port_arbiter: RTL and testbench

//  Single-owner controller for the data memory. It shares one memory port between two

---
 rtl/dmem_port_arbiter_pkg.sv | 36 +++
 rtl/dmem_port_arbiter_if.sv | 32 +++
 rtl/dmem_port_arbiter_pick.sv | 49 ++++
 rtl/dmem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg
// Shared types and constants for the data-memory port arbiter:
//   arb_state_t  - arbiter FSM state codes (IDLE / WAIT)
//   owner_t      - requester IDs (P = MEM stage, D = debug/loader)
//   GNT_P/GNT_D  - bit positions in the one-hot grant vector
//   LAT_W        - width of the read-latency counter (MEM_LAT 1..4)
//   STARVE_W     - width of the starvation counter (STARVE_MAX 1..15)
//   req_bundle_width/rsp_bundle_width - packed widths of one request/response
package dmem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_P = 1'b0,
        REQ_D = 1'b1
    } owner_t;

    localparam int GNT_P    = 0;
    localparam int GNT_D    = 1;
    localparam int LAT_W    = 2;
    localparam int STARVE_W = 4;

    // valid + we + addr + wdata
    function automatic int req_bundle_width(input int dbits);
        return 2 + 2 * dbits;
    endfunction

    // valid + rdata
    function automatic int rsp_bundle_width(input int dbits);
        return 1 + dbits;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
// One requester's request/response channel into the arbiter.
//   req_valid/req_ready  request handshake (accepted when both high)
//   req_we               1 = store, 0 = load
//   req_addr/req_wdata   byte address and store data
//   rsp_valid/rsp_rdata  one-cycle response pulse and load data (0 for stores)
// Modports: master = requester side, slave = arbiter side.
interface dmem_port_arbiter_if
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DBITS = 32
);

    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [DBITS-1:0] req_addr;
    logic [DBITS-1:0] req_wdata;
    logic             rsp_valid;
    logic [DBITS-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/dmem_port_arbiter_pick.sv
// dmem_arb_pick
// Grant selection between P (priority) and D with a starvation guard.
//   clk, reset  clock and synchronous active-high reset
//   p_valid     P request valid
//   d_valid     D request valid
//   idle        arbiter is able to accept a request this cycle
//   grant       one-hot grant, bit GNT_P / GNT_D; all zero when not idle
module dmem_arb_pick
    import dmem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_valid,
    input  logic       d_valid,
    input  logic       idle,
    output logic [1:0] grant
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starved;

    assign starved = (starve_cnt == STARVE_W'(STARVE_MAX));

    always_comb begin
        grant = '0;
        if (idle) begin
            if (d_valid && (!p_valid || starved)) begin
                grant[GNT_D] = 1'b1;
            end else if (p_valid) begin
                grant[GNT_P] = 1'b1;
            end
        end
    end

    // Only lost arbitration rounds count; while a read is outstanding the
    // count is frozen so D is not charged for cycles nobody could be served.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!d_valid || grant[GNT_D]) begin
            starve_cnt <= '0;
        end else if (idle && !starved) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Single owner of the data-memory port, shared by the MEM stage (P, high
// priority) and a debug/loader port (D). One access outstanding at a time;
// stores complete in one cycle, loads wait MEM_LAT cycles for mem_rdata.
//   clk, reset       clock and synchronous active-high reset
//   p, d             requester channels (dmem_port_arbiter_if.slave)
//   mem_en/mem_we    memory strobe and write enable (combinational from grant)
//   mem_addr/wdata   memory byte address and write data
//   mem_rdata        memory read data, valid MEM_LAT cycles after issue
//   busy             a read is outstanding
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DBITS      = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    dmem_port_arbiter_if.slave p,
    dmem_port_arbiter_if.slave d,
    output logic             mem_en,
    output logic             mem_we,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata,
    output logic             busy
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [LAT_W-1:0] lat_cnt;
    owner_t           owner;
    logic [1:0]       grant;
    logic             idle;
    logic             p_rsp_valid;
    logic             d_rsp_valid;
    logic [DBITS-1:0] p_rsp_rdata;
    logic [DBITS-1:0] d_rsp_rdata;

    // Reset folds into idle so nothing can be granted while it is held.
    assign idle = (state == ARB_IDLE) && !reset;

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk     (clk),
        .reset   (reset),
        .p_valid (p.req_valid),
        .d_valid (d.req_valid),
        .idle    (idle),
        .grant   (grant)
    );

    assign p.req_ready = grant[GNT_P];
    assign d.req_ready = grant[GNT_D];
    assign p.rsp_valid = p_rsp_valid;
    assign d.rsp_valid = d_rsp_valid;
    assign p.rsp_rdata = p_rsp_rdata;
    assign d.rsp_rdata = d_rsp_rdata;
    assign busy        = (state != ARB_IDLE);

    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = p.req_addr;
        mem_wdata  = p.req_wdata;
        if (grant[GNT_D]) begin
            mem_addr  = d.req_addr;
            mem_wdata = d.req_wdata;
        end
        case (state)
            ARB_IDLE: begin
                mem_en = |grant;
                mem_we = grant[GNT_D] ? d.req_we : (grant[GNT_P] & p.req_we);
                if (mem_en && !mem_we) begin
                    state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (lat_cnt == '0) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Response pulses default low every cycle; a store answers one cycle after
    // acceptance, a load answers the cycle after mem_rdata is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt     <= '0;
            owner       <= REQ_P;
            p_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            p_rsp_rdata <= '0;
            d_rsp_rdata <= '0;
        end else begin
            p_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            if (state == ARB_IDLE) begin
                if (mem_en) begin
                    owner <= grant[GNT_D] ? REQ_D : REQ_P;
                    if (mem_we) begin
                        if (grant[GNT_D]) begin
                            d_rsp_valid <= 1'b1;
                            d_rsp_rdata <= '0;
                        end else begin
                            p_rsp_valid <= 1'b1;
                            p_rsp_rdata <= '0;
                        end
                    end else begin
                        lat_cnt <= LAT_W'(MEM_LAT - 1);
                    end
                end
            end else if (lat_cnt == '0) begin
                if (owner == REQ_D) begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_rdata <= mem_rdata;
                end else begin
                    p_rsp_valid <= 1'b1;
                    p_rsp_rdata <= mem_rdata;
                end
            end else begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Bench for dmem_port_arbiter with MEM_LAT=2, STARVE_MAX=8: a cycle table of
// directed vectors, a starvation sequence with both ports always valid, and a
// randomized phase checked against a transaction-level reference model.
module tb_dmem_port_arbiter;

    localparam int DBITS       = 32;
    localparam int MEM_LAT     = 2;
    localparam int STARVE_MAX  = 8;
    localparam int NUM_VEC     = 24;
    localparam int RAND_CYCLES = 3000;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_en;
    logic             mem_we;
    logic [DBITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_wdata;
    logic [DBITS-1:0] mem_rdata;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.DBITS(DBITS)) p_if();
    dmem_port_arbiter_if #(.DBITS(DBITS)) d_if();

    dmem_port_arbiter #(
        .DBITS      (DBITS),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p         (p_if),
        .d         (d_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Memory array with a MEM_LAT-deep read pipe; rdata is poisoned outside
    // the single cycle it is defined, so off-by-one captures are visible.
    logic [31:0] tb_mem [0:63];
    logic [5:0]  rd_idx [0:MEM_LAT-1];
    logic        rd_vld [0:MEM_LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;
        rd_vld[0] <= mem_en && !mem_we;
        rd_idx[0] <= mem_addr[7:2];
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_vld[i] <= rd_vld[i-1];
            rd_idx[i] <= rd_idx[i-1];
        end
    end

    assign mem_rdata = rd_vld[MEM_LAT-1] ? tb_mem[rd_idx[MEM_LAT-1]] : 32'hBAD0_BAD0;

    typedef struct {
        logic        rst;
        logic        pv;
        logic        pwe;
        logic [31:0] paddr;
        logic [31:0] pwd;
        logic        dv;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        e_pready;
        logic        e_dready;
        logic        e_prsp;
        logic [31:0] e_prdata;
        logic        e_drsp;
        logic [31:0] e_drdata;
        logic        e_busy;
        logic        e_mem_en;
    } vec_t;

    typedef struct {
        int          due;
        logic        port;
        logic [31:0] data;
    } rsp_t;

    vec_t vec [0:NUM_VEC-1];
    rsp_t rsp_q [$];

    task automatic apply_stimulus(input logic rst,
                                  input logic pv, input logic pwe,
                                  input logic [31:0] paddr, input logic [31:0] pwd,
                                  input logic dv, input logic dwe,
                                  input logic [31:0] daddr, input logic [31:0] dwd);
        reset            = rst;
        p_if.req_valid   = pv;
        p_if.req_we      = pwe;
        p_if.req_addr    = paddr;
        p_if.req_wdata   = pwd;
        d_if.req_valid   = dv;
        d_if.req_we      = dwe;
        d_if.req_addr    = daddr;
        d_if.req_wdata   = dwd;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    logic        p_pend, d_pend;
    logic        p_we_r, d_we_r;
    logic [31:0] p_addr_r, d_addr_r, p_wd_r, d_wd_r;
    logic [31:0] model_mem [0:15];
    logic        free, gp, gd;
    logic        e_prsp, e_drsp;
    logic [31:0] e_prdata, e_drdata;
    int          free_at, lost;

    initial begin
        //            rst pv pwe paddr   pwd            dv dwe daddr  dwd       pr dr prsp prdata        drsp drdata   busy men
        vec[0]  = '{1, 1, 0, 32'h40, 32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    0, 0};
        vec[1]  = '{0, 0, 0, 32'h0,  32'h0,         1, 1, 32'h10, 32'h1234, 0, 1, 0, 32'h0,        0, 32'h0,    0, 1};
        vec[2]  = '{0, 1, 1, 32'h40, 32'hDEADBEEF,  0, 0, 32'h0,  32'h0,    1, 0, 0, 32'h0,        1, 32'h0,    0, 1};
        vec[3]  = '{0, 1, 0, 32'h40, 32'h0,         0, 0, 32'h0,  32'h0,    1, 0, 1, 32'h0,        0, 32'h0,    0, 1};
        vec[4]  = '{0, 0, 0, 32'h0,  32'h0,         1, 0, 32'h10, 32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    1, 0};
        vec[5]  = '{0, 0, 0, 32'h0,  32'h0,         1, 0, 32'h10, 32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    1, 0};
        vec[6]  = '{0, 0, 0, 32'h0,  32'h0,         1, 0, 32'h10, 32'h0,    0, 1, 1, 32'hDEADBEEF, 0, 32'h0,    0, 1};
        vec[7]  = '{0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    1, 0};
        vec[8]  = '{0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    1, 0};
        vec[9]  = '{0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        1, 32'h1234, 0, 0};
        vec[10] = '{0, 1, 0, 32'h10, 32'h0,         0, 0, 32'h0,  32'h0,    1, 0, 0, 32'h0,        0, 32'h0,    0, 1};
        vec[11] = '{0, 1, 0, 32'h40, 32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    1, 0};
        vec[12] = '{0, 1, 0, 32'h40, 32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    1, 0};
        vec[13] = '{0, 1, 0, 32'h40, 32'h0,         0, 0, 32'h0,  32'h0,    1, 0, 1, 32'h1234,     0, 32'h0,    0, 1};
        vec[14] = '{0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    1, 0};
        vec[15] = '{0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    1, 0};
        vec[16] = '{0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 1, 32'hDEADBEEF, 0, 32'h0,    0, 0};
        vec[17] = '{0, 1, 0, 32'h40, 32'h0,         0, 0, 32'h0,  32'h0,    1, 0, 0, 32'h0,        0, 32'h0,    0, 1};
        vec[18] = '{1, 1, 0, 32'h44, 32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    1, 0};
        vec[19] = '{0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    0, 0};
        vec[20] = '{0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    0, 0};
        vec[21] = '{0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        0, 32'h0,    0, 0};
        vec[22] = '{0, 0, 0, 32'h0,  32'h0,         1, 1, 32'h44, 32'hCAFE, 0, 1, 0, 32'h0,        0, 32'h0,    0, 1};
        vec[23] = '{0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,        1, 32'h0,    0, 0};

        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        // Directed cycle table: store/load, D alone, back-to-back loads, reset mid-load.
        for (int i = 0; i < NUM_VEC; i++) begin
            @(posedge clk); #1;
            apply_stimulus(vec[i].rst, vec[i].pv, vec[i].pwe, vec[i].paddr, vec[i].pwd,
                           vec[i].dv, vec[i].dwe, vec[i].daddr, vec[i].dwd);
            @(negedge clk);
            check_output($sformatf("vec%0d p_req_ready", i), 32'(p_if.req_ready), 32'(vec[i].e_pready));
            check_output($sformatf("vec%0d d_req_ready", i), 32'(d_if.req_ready), 32'(vec[i].e_dready));
            check_output($sformatf("vec%0d p_rsp_valid", i), 32'(p_if.rsp_valid), 32'(vec[i].e_prsp));
            check_output($sformatf("vec%0d d_rsp_valid", i), 32'(d_if.rsp_valid), 32'(vec[i].e_drsp));
            check_output($sformatf("vec%0d busy", i), 32'(busy), 32'(vec[i].e_busy));
            check_output($sformatf("vec%0d mem_en", i), 32'(mem_en), 32'(vec[i].e_mem_en));
            if (vec[i].e_prsp) check_output($sformatf("vec%0d p_rsp_rdata", i), p_if.rsp_rdata, vec[i].e_prdata);
            if (vec[i].e_drsp) check_output($sformatf("vec%0d d_rsp_rdata", i), d_if.rsp_rdata, vec[i].e_drdata);
        end

        // Both ports store every cycle: D must win exactly every STARVE_MAX+1 cycles.
        for (int i = 0; i < 4 * (STARVE_MAX + 1); i++) begin
            @(posedge clk); #1;
            apply_stimulus(0, 1, 1, 32'h80 + 32'(4 * (i % 8)), 32'(i), 1, 1, 32'hC0, 32'h5A00 + 32'(i));
            @(negedge clk);
            check_output($sformatf("starve%0d d_req_ready", i), 32'(d_if.req_ready),
                         32'((i % (STARVE_MAX + 1)) == STARVE_MAX));
            check_output($sformatf("starve%0d p_req_ready", i), 32'(p_if.req_ready),
                         32'((i % (STARVE_MAX + 1)) != STARVE_MAX));
        end

        // Fill the 16 words used by the random phase through port D.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            model_mem[i] = $urandom;
            apply_stimulus(0, 0, 0, 0, 0, 1, 1, 32'(i * 4), model_mem[i]);
            @(negedge clk);
            check_output($sformatf("fill%0d d_req_ready", i), 32'(d_if.req_ready), 32'd1);
        end
        @(posedge clk); #1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Randomized traffic against a transaction-level model.
        p_pend = 0; d_pend = 0;
        p_we_r = 0; d_we_r = 0;
        p_addr_r = 0; d_addr_r = 0; p_wd_r = 0; d_wd_r = 0;
        free_at = 0; lost = 0;
        for (int k = 0; k < RAND_CYCLES; k++) begin
            @(posedge clk); #1;
            if (!p_pend && $urandom_range(0, 99) < 55) begin
                p_pend   = 1;
                p_we_r   = 1'($urandom_range(0, 1));
                p_addr_r = 32'($urandom_range(0, 15)) << 2;
                p_wd_r   = $urandom;
            end
            if (!d_pend && $urandom_range(0, 99) < 45) begin
                d_pend   = 1;
                d_we_r   = 1'($urandom_range(0, 1));
                d_addr_r = 32'($urandom_range(0, 15)) << 2;
                d_wd_r   = $urandom;
            end
            apply_stimulus(0, p_pend, p_we_r, p_addr_r, p_wd_r, d_pend, d_we_r, d_addr_r, d_wd_r);
            @(negedge clk);

            free = (k >= free_at);
            gd   = free && d_pend && (!p_pend || lost >= STARVE_MAX);
            gp   = free && p_pend && !gd;

            e_prsp = 0; e_drsp = 0; e_prdata = 0; e_drdata = 0;
            for (int j = rsp_q.size() - 1; j >= 0; j--) begin
                if (rsp_q[j].due == k) begin
                    if (rsp_q[j].port) begin e_drsp = 1; e_drdata = rsp_q[j].data; end
                    else               begin e_prsp = 1; e_prdata = rsp_q[j].data; end
                    rsp_q.delete(j);
                end
            end

            check_output($sformatf("rand%0d p_req_ready", k), 32'(p_if.req_ready), 32'(gp));
            check_output($sformatf("rand%0d d_req_ready", k), 32'(d_if.req_ready), 32'(gd));
            check_output($sformatf("rand%0d p_rsp_valid", k), 32'(p_if.rsp_valid), 32'(e_prsp));
            check_output($sformatf("rand%0d d_rsp_valid", k), 32'(d_if.rsp_valid), 32'(e_drsp));
            check_output($sformatf("rand%0d busy", k), 32'(busy), 32'(!free));
            check_output($sformatf("rand%0d mem_en", k), 32'(mem_en), 32'(gp || gd));
            if (e_prsp) check_output($sformatf("rand%0d p_rsp_rdata", k), p_if.rsp_rdata, e_prdata);
            if (e_drsp) check_output($sformatf("rand%0d d_rsp_rdata", k), d_if.rsp_rdata, e_drdata);
            if (gp) begin
                check_output($sformatf("rand%0d mem_we", k), 32'(mem_we), 32'(p_we_r));
                check_output($sformatf("rand%0d mem_addr", k), mem_addr, p_addr_r);
            end
            if (gd) begin
                check_output($sformatf("rand%0d mem_we", k), 32'(mem_we), 32'(d_we_r));
                check_output($sformatf("rand%0d mem_addr", k), mem_addr, d_addr_r);
            end

            if (gp) begin
                if (p_we_r) begin
                    model_mem[p_addr_r[5:2]] = p_wd_r;
                    rsp_q.push_back('{k + 1, 1'b0, 32'h0});
                end else begin
                    rsp_q.push_back('{k + MEM_LAT + 1, 1'b0, model_mem[p_addr_r[5:2]]});
                    free_at = k + MEM_LAT + 1;
                end
                p_pend = 0;
            end
            if (gd) begin
                if (d_we_r) begin
                    model_mem[d_addr_r[5:2]] = d_wd_r;
                    rsp_q.push_back('{k + 1, 1'b1, 32'h0});
                end else begin
                    rsp_q.push_back('{k + MEM_LAT + 1, 1'b1, model_mem[d_addr_r[5:2]]});
                    free_at = k + MEM_LAT + 1;
                end
            end
            if (!d_pend || gd)   lost = 0;
            else if (free)       lost = (lost < STARVE_MAX) ? lost + 1 : STARVE_MAX;
            if (gd) d_pend = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
